// File: rtl/mc_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Optional: MC_CTRL_ILLEGAL_TRAP_EN halts on illegal instructions.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        less,
  input  logic        zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_op,
  output logic [3:0]  alu_ctr,
  output logic        alu_asrc,
  output logic [1:0]  alu_bsrc,
  output logic [2:0]  ext_op,
  output logic        reg_wr,
  output logic        wb_sel,
  output logic        pc_wr,
  output logic [1:0]  pc_sel,
  output logic        illegal,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  state_t      state_q;
  logic [31:0] ir_q;
  logic        illegal_q;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        f7b;
  logic        unused_ir;

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign f7b = ir_q[30];
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  logic       legal;
  logic       is_ld, is_st, is_br, is_jal, is_jalr;
  logic [2:0] ext_d;
  logic [3:0] alu_d;
  logic       asrc_d;
  logic [1:0] bsrc_d;
  logic       taken;

  always_comb begin
    legal   = 1'b1;
    ext_d   = 3'b000;
    alu_d   = 4'b0000;
    asrc_d  = 1'b0;
    bsrc_d  = 2'b00;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    case (opc)
      OP_LUI: begin
        ext_d  = 3'b001;
        alu_d  = 4'b1111;
        bsrc_d = 2'b01;
      end
      OP_AUIPC: begin
        ext_d  = 3'b001;
        asrc_d = 1'b1;
        bsrc_d = 2'b01;
      end
      OP_JAL: begin
        ext_d  = 3'b100;
        asrc_d = 1'b1;
        bsrc_d = 2'b10;
        is_jal = 1'b1;
      end
      OP_JALR: begin
        asrc_d  = 1'b1;
        bsrc_d  = 2'b10;
        is_jalr = 1'b1;
        legal   = (f3 == 3'b000);
      end
      OP_BR: begin
        ext_d = 3'b011;
        is_br = 1'b1;
        legal = (f3[2:1] != 2'b01);
        alu_d = !f3[2] ? 4'b1000 : {3'b001, f3[1]};
      end
      OP_LD: begin
        bsrc_d = 2'b01;
        is_ld  = 1'b1;
        legal  = (f3 != 3'b011) && (f3[2:1] != 2'b11);
      end
      OP_ST: begin
        ext_d  = 3'b010;
        bsrc_d = 2'b01;
        is_st  = 1'b1;
        legal  = !f3[2] && (f3 != 3'b011);
      end
      OP_IMM: begin
        bsrc_d = 2'b01;
        alu_d  = {(f3 == 3'b101) & f7b, f3};
      end
      OP_REG: begin
        alu_d = {((f3 == 3'b000) || (f3 == 3'b101)) & f7b, f3};
      end
      default: legal = 1'b0;
    endcase
  end

  // funct3[0] inverts the sense: BNE/BGE/BGEU
  assign taken = f3[0] ^ (f3[2] ? less : zero);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:
          if (mem_ready) begin
            ir_q    <= instr;
            state_q <= S_DECODE;
          end
        S_DECODE:
          if (legal) state_q <= S_EXEC;
          else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
`else
            state_q   <= S_FETCH;
`endif
          end
        S_EXEC:
          if (is_br) state_q <= S_FETCH;
          else if (is_ld || is_st) state_q <= S_MEM;
          else state_q <= S_WB;
        S_MEM:
          if (mem_ready) state_q <= is_ld ? S_WB : S_FETCH;
        S_WB:    state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_op   = 3'b000;
    alu_ctr  = 4'b0000;
    alu_asrc = 1'b0;
    alu_bsrc = 2'b00;
    ext_op   = 3'b000;
    reg_wr   = 1'b0;
    wb_sel   = 1'b0;
    pc_wr    = 1'b0;
    pc_sel   = 2'b00;
    illegal  = 1'b0;
    state_o  = 3'b000;
    if (rst_n) begin
      state_o = state_q;
      illegal = illegal_q;
      mem_op  = f3;
      case (state_q)
        S_FETCH: mem_req = 1'b1;
        S_DECODE: begin
          ext_op = ext_d;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
          pc_wr  = !legal;
`endif
        end
        S_EXEC: begin
          ext_op   = ext_d;
          alu_ctr  = alu_d;
          alu_asrc = asrc_d;
          alu_bsrc = bsrc_d;
          if (is_br) begin
            pc_wr  = 1'b1;
            pc_sel = taken ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          ext_op   = ext_d;
          alu_ctr  = alu_d;
          alu_asrc = asrc_d;
          alu_bsrc = bsrc_d;
          mem_req  = 1'b1;
          mem_we   = is_st;
          pc_wr    = is_st & mem_ready;
        end
        S_WB: begin
          ext_op   = ext_d;
          alu_ctr  = alu_d;
          alu_asrc = asrc_d;
          alu_bsrc = bsrc_d;
          reg_wr   = 1'b1;
          pc_wr    = 1'b1;
          wb_sel   = is_ld;
          pc_sel   = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl.
// Covers ALU/branch/memory sequencing, reset abort and illegal handling.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready, less, zero;
  logic        mem_req, mem_we;
  logic [2:0]  mem_op;
  logic [3:0]  alu_ctr;
  logic        alu_asrc;
  logic [1:0]  alu_bsrc;
  logic [2:0]  ext_op;
  logic        reg_wr, wb_sel, pc_wr;
  logic [1:0]  pc_sel;
  logic        illegal;
  logic [2:0]  state_o;

  int pass_cnt = 0;
  int total = 0;
  int pcw = 0;
  int rgw = 0;
  int p0, r0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .mem_ready(mem_ready), .less(less), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .mem_op(mem_op),
    .alu_ctr(alu_ctr), .alu_asrc(alu_asrc), .alu_bsrc(alu_bsrc),
    .ext_op(ext_op), .reg_wr(reg_wr), .wb_sel(wb_sel),
    .pc_wr(pc_wr), .pc_sel(pc_sel), .illegal(illegal),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_wr)  pcw <= pcw + 1;
    if (reg_wr) rgw <= rgw + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    instr = w;
    mem_ready = 1'b1;
    #1;
    chk("fetch_state", state_o, 0);
    chk("fetch_req", mem_req, 1);
    chk("fetch_we", mem_we, 0);
    tick();
    mem_ready = 1'b0;
    instr = 32'hDEADBEEF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    instr = 32'h0;
    mem_ready = 1'b0;
    less = 1'b0;
    zero = 1'b0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_state", state_o, 0);
    tick();
    tick();
    chk("rst_illegal", illegal, 0);
    chk("rst_pcwr", pc_wr, 0);
    rst_n = 1'b1;

    // ADD x3,x1,x2: 4 cycles
    p0 = pcw; r0 = rgw;
    fetch(32'h002081B3);
    chk("add_dec_state", state_o, 1);
    chk("add_dec_req", mem_req, 0);
    tick();
    chk("add_ex_state", state_o, 2);
    chk("add_ex_alu", alu_ctr, 4'b0000);
    chk("add_ex_pcwr", pc_wr, 0);
    chk("add_ex_regwr", reg_wr, 0);
    tick();
    chk("add_wb_state", state_o, 4);
    chk("add_wb_regwr", reg_wr, 1);
    chk("add_wb_pcwr", pc_wr, 1);
    chk("add_wb_sel", wb_sel, 0);
    chk("add_wb_pcsel", pc_sel, 0);
    tick();
    chk("add_done", state_o, 0);
    chk("add_pcw_cnt", pcw - p0, 1);
    chk("add_rgw_cnt", rgw - r0, 1);

    // LW with two wait cycles: 7 cycles
    fetch(32'h0000A183);
    tick();
    chk("lw_ex_alu", alu_ctr, 4'b0000);
    chk("lw_ex_bsrc", alu_bsrc, 2'b01);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("lw_wait_state", state_o, 3);
      chk("lw_wait_req", mem_req, 1);
      chk("lw_wait_we", mem_we, 0);
      chk("lw_wait_op", mem_op, 3'b010);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_rdy_req", mem_req, 1);
    chk("lw_rdy_pcwr", pc_wr, 0);
    tick();
    mem_ready = 1'b0;
    chk("lw_wb_state", state_o, 4);
    chk("lw_wb_sel", wb_sel, 1);
    chk("lw_wb_regwr", reg_wr, 1);
    tick();
    chk("lw_done", state_o, 0);

    // BLTU taken then not taken: 3 cycles each
    p0 = pcw; r0 = rgw;
    fetch(32'h0020E463);
    tick();
    less = 1'b1;
    #1;
    chk("bltu_t_alu", alu_ctr, 4'b0011);
    chk("bltu_t_pcsel", pc_sel, 2'b01);
    chk("bltu_t_pcwr", pc_wr, 1);
    chk("bltu_t_regwr", reg_wr, 0);
    tick();
    chk("bltu_t_done", state_o, 0);
    fetch(32'h0020E463);
    tick();
    less = 1'b0;
    #1;
    chk("bltu_n_pcsel", pc_sel, 2'b00);
    chk("bltu_n_pcwr", pc_wr, 1);
    tick();
    chk("bltu_n_done", state_o, 0);
    chk("bltu_pcw_cnt", pcw - p0, 2);
    chk("bltu_rgw_cnt", rgw - r0, 0);

    // SRAI x3,x1,2
    fetch(32'h4020D193);
    tick();
    chk("srai_alu", alu_ctr, 4'b1101);
    chk("srai_bsrc", alu_bsrc, 2'b01);
    tick();
    tick();

    // LUI x1,0x12345
    fetch(32'h123450B7);
    chk("lui_ext", ext_op, 3'b001);
    tick();
    chk("lui_alu", alu_ctr, 4'b1111);
    chk("lui_bsrc", alu_bsrc, 2'b01);
    tick();
    tick();

    // JALR x1,0(x2)
    fetch(32'h000100E7);
    tick();
    chk("jalr_ex_state", state_o, 2);
    tick();
    chk("jalr_wb_state", state_o, 4);
    chk("jalr_asrc", alu_asrc, 1);
    chk("jalr_bsrc", alu_bsrc, 2'b10);
    chk("jalr_alu", alu_ctr, 4'b0000);
    chk("jalr_pcsel", pc_sel, 2'b10);
    tick();
    chk("jalr_done", state_o, 0);

    // SW zero-wait: 4 cycles
    p0 = pcw; r0 = rgw;
    fetch(32'h0020A023);
    tick();
    tick();
    mem_ready = 1'b1;
    #1;
    chk("sw_mem_we", mem_we, 1);
    chk("sw_pcwr", pc_wr, 1);
    chk("sw_pcsel", pc_sel, 2'b00);
    tick();
    mem_ready = 1'b0;
    chk("sw_done", state_o, 0);
    chk("sw_rgw_cnt", rgw - r0, 0);

    // SW with reset during the MEM wait
    fetch(32'h0020A023);
    tick();
    tick();
    chk("swr_state", state_o, 3);
    chk("swr_we", mem_we, 1);
    tick();
    chk("swr_wait", state_o, 3);
    rst_n = 1'b0;
    #1;
    chk("swr_rst_req", mem_req, 0);
    tick();
    chk("swr_held_req", mem_req, 0);
    chk("swr_held_state", state_o, 0);
    rst_n = 1'b1;
    #1;
    chk("swr_post_state", state_o, 0);
    chk("swr_post_req", mem_req, 1);

    // All-zero word is illegal
    p0 = pcw;
    fetch(32'h00000000);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    tick();
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("ill_state", state_o, 7);
      chk("ill_flag", illegal, 1);
      chk("ill_req", mem_req, 0);
      chk("ill_pcwr", pc_wr, 0);
      tick();
    end
    mem_ready = 1'b0;
`else
    #1;
    chk("ill_pcwr", pc_wr, 1);
    chk("ill_pcsel", pc_sel, 2'b00);
    tick();
    chk("ill_state", state_o, 0);
    chk("ill_flag", illegal, 0);
    chk("ill_pcw_cnt", pcw - p0, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control unit for the RV32I datapath. It latches the fetched instruction, then sequences the FETCH/DECODE/EXEC/MEM/WB states, and drives the ALU control word, operand selects, register/memory/PC strobes and the memory handshake. It consumes the ALU's `less`/`zero` flags to resolve branches. It sits between the instruction/data memory port and the existing datapath (register file, immediate extender, ALU, PC).

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `instr` in 32: memory read data; captured as instruction in FETCH.
- `mem_ready` in 1: memory completes current request this cycle.
- `less` in 1: ALU less flag.
- `zero` in 1: ALU zero flag.
- `mem_req` out 1: memory request; held until `mem_ready`.
- `mem_we` out 1: write qualifier for `mem_req`.
- `mem_op` out 3: access size/sign, equal to latched funct3.
- `alu_ctr` out 4: ALU control word.
- `alu_asrc` out 1: 0=rs1, 1=PC.
- `alu_bsrc` out 2: 00=rs2, 01=imm, 10=constant 4.
- `ext_op` out 3: I=000, U=001, S=010, B=011, J=100.
- `reg_wr` out 1: register file write strobe.
- `wb_sel` out 1: 0=ALU result, 1=memory data.
- `pc_wr` out 1: PC update strobe.
- `pc_sel` out 2: 00=PC+4, 01=PC+imm, 10=(rs1+imm)&~1.
- `illegal` out 1: sticky illegal-instruction flag.
- `state_o` out 3: current state, for debug display.

## Operation
- States (`state_o` encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- **FETCH**: `mem_req`=1, `mem_we`=0. On `mem_ready`: latch `instr` into internal IR, then go to DECODE. Otherwise stay.
- **DECODE**: decode opcode/funct3/funct7[5] from IR and drive `ext_op`. Then go to EXEC, or apply the illegal handling (see Configuration).
- **EXEC**: drive `alu_ctr`/srcs.
  - OP/OP-IMM, LUI, AUIPC, JAL, JALR → WB.
  - LOAD/STORE → MEM.
  - BRANCH → FETCH, with `pc_wr`=1.
- **MEM**: `mem_req`=1, `mem_we`=store. Hold state and all outputs until `mem_ready`.
  - Load → WB.
  - Store → FETCH, with `pc_wr`=1, `pc_sel`=00.
- **WB**: `reg_wr`=1 and `pc_wr`=1, then → FETCH.
  - `wb_sel`=1 for loads only.
  - `pc_sel`: 01 for JAL, 10 for JALR, 00 otherwise.
  - JAL/JALR writeback uses `alu_asrc`=1, `alu_bsrc`=10, `alu_ctr`=add. The ALU output is held by the datapath result register.
- **ALU control encoding**:
  - add 0000, sub 1000
  - sll 0001, srl 0101, sra 1101
  - slt 0010, sltu 0011
  - xor 0100, or 0110, and 0111
  - pass-B 1111 (LUI)
- **Per-instruction ALU use**:
  - Loads, stores and AUIPC use add. LUI uses pass-B with imm.
  - OP-IMM sub does not exist: funct3=000 is always add.
  - SRAI/SRA are selected by funct7[5].
- **Branch compare** (rs1 vs rs2):
  - BEQ/BNE use sub; taken on `zero` / `!zero`.
  - BLT/BGE use 0010; taken on `less` / `!less`.
  - BLTU/BGEU use 0011; taken on `less` / `!less`.
  - Taken → `pc_sel`=01; not taken → 00.
- All control outputs are combinational from the state register and IR. Strobes are single-cycle.

## Timing
- Reset (`rst_n` low at an edge): state=FETCH, IR=0, `illegal`=0.
- While `rst_n` is low, all outputs are forced to 0, including `mem_req`. This also applies mid-access: the request drops and is reissued after reset.
- Cycle counts with zero-wait memory (`mem_ready` high on the first request cycle):
  - Branch: 3.
  - Store, OP/OP-IMM, LUI, AUIPC, JAL, JALR: 4.
  - Load: 5.
- Each wait cycle adds one cycle in FETCH or MEM.
- `mem_ready` is ignored when `mem_req`=0.
- `instr` is sampled only on the FETCH edge where `mem_ready`=1.
- Exactly one `pc_wr` pulse per retired instruction. `reg_wr` is never asserted for branch or store.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN`
  - Defined: an unknown opcode, or a funct3 invalid for the opcode, makes DECODE go to HALT. HALT is absorbing until reset, with `illegal`=1 and all strobes 0.
  - Undefined: an illegal instruction is treated as NOP. DECODE goes to FETCH with `pc_wr`=1, `pc_sel`=00, and `illegal` stays 0.

## Test plan
- ADD x3,x1,x2 (0x002081B3), zero-wait → states 0,1,2,4; `alu_ctr`=0000 in EXEC; `reg_wr`=`pc_wr`=1 in WB only; 4 cycles.
- LW (0x0000A183) with `mem_ready` delayed 2 cycles in MEM → `mem_req` held 3 cycles, `mem_we`=0; WB `wb_sel`=1; 7 cycles total.
- BLTU (funct3=110) → `alu_ctr`=0011.
  - `less`=1 → `pc_sel`=01, `pc_wr`=1 at EXEC.
  - `less`=0 → `pc_sel`=00.
  - No `reg_wr` in either case.
- SRAI (0x4020D193) → `alu_ctr`=1101, `alu_bsrc`=01; LUI → `alu_ctr`=1111, `ext_op`=001.
- JALR → WB with `alu_asrc`=1, `alu_bsrc`=10, `pc_sel`=10.
- Reset pulse asserted during a SW MEM wait → next cycle state=FETCH, `mem_req`=0 while reset is held.
- Opcode 0x00000000:
  - With `MC_CTRL_ILLEGAL_TRAP_EN`: `state_o`=7, `illegal`=1, persists 10 cycles.
  - Without: returns to FETCH with one `pc_wr` pulse.
